// File: rtl/stage23_reg_pkg.sv
// Shared pipeline definitions for the phase 2/3 boundary: widths, field positions
// within an instruction, and ALU operation encodings.
package stage23_reg_pkg;

   localparam int PIPE_DW = 16;
   localparam int PIPE_RW = 3;

   localparam int RS_LSB = 11;
   localparam int RD_LSB = 8;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SUB   = 4'h1,
      ALU_AND   = 4'h2,
      ALU_OR    = 4'h3,
      ALU_XOR   = 4'h4,
      ALU_SLL   = 4'h5,
      ALU_SRL   = 4'h6,
      ALU_SLT   = 4'h7,
      ALU_PASSB = 4'h8
   } alu_op_e;

endpackage

// File: rtl/stage23_reg_load_use_detect.sv
// Combinational load-use hazard: the instruction in phase 1/2 reads a register
// that the load now in phase 2/3 has not yet fetched from memory.
module load_use_detect
   import stage23_reg_pkg::*;
#(
   parameter int RW = PIPE_RW
) (
   input  logic          valid1_2,
   input  logic          valid2_3,
   input  logic          mem_read2_3,
   input  logic          use_a,
   input  logic          use_b,
   input  logic [RW-1:0] wreg2_3,
   input  logic [RW-1:0] rs,
   input  logic [RW-1:0] rd,
   output logic          hazard
);

   logic match_a;
   logic match_b;

   always_comb begin
      match_a = use_a && (wreg2_3 == rs);
      match_b = use_b && (wreg2_3 == rd);
      hazard  = valid1_2 && valid2_3 && mem_read2_3 && (match_a || match_b);
   end

endmodule

// File: rtl/stage23_reg.sv
// Phase 2/3 pipeline register with load-use stall, flush-to-bubble and a
// saturating count of the bubbles inserted by stalls.
module stage23_reg
   import stage23_reg_pkg::*;
#(
   parameter int DW = PIPE_DW,
   parameter int RW = PIPE_RW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   instr1_2,
   input  logic            valid1_2,
   input  logic [DW-1:0]   pc1_2,
   input  logic [DW-1:0]   rdata_a,
   input  logic [DW-1:0]   rdata_b,
   input  logic            RegWrite_d,
   input  logic            MemRead_d,
   input  logic            MemWrite_d,
   input  logic            useA_d,
   input  logic            useB_d,
   input  logic [3:0]      ALUop_d,
   input  logic [RW-1:0]   wreg_d,
   input  logic [DW-1:0]   imm_d,
   input  logic            flush,
   output logic            RegWrite2_3,
   output logic            MemRead2_3,
   output logic            MemWrite2_3,
   output logic            valid2_3,
   output logic [3:0]      ALUop2_3,
   output logic [RW-1:0]   wreg2_3,
   output logic [2*RW-1:0] rsrd2_3,
   output logic [DW-1:0]   a2_3,
   output logic [DW-1:0]   b2_3,
   output logic [DW-1:0]   imm2_3,
   output logic [DW-1:0]   pc2_3,
   output logic            stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic [RW-1:0] rs;
   logic [RW-1:0] rd;
   logic          hazard;
   logic          unused_instr_bits;

   assign rs = instr1_2[RS_LSB +: RW];
   assign rd = instr1_2[RD_LSB +: RW];
   assign unused_instr_bits = ^{instr1_2[DW-1:RS_LSB+RW], instr1_2[RD_LSB-1:0]};

   load_use_detect #(.RW(RW)) u_detect (
      .valid1_2    (valid1_2),
      .valid2_3    (valid2_3),
      .mem_read2_3 (MemRead2_3),
      .use_a       (useA_d),
      .use_b       (useB_d),
      .wreg2_3     (wreg2_3),
      .rs          (rs),
      .rd          (rd),
      .hazard      (hazard)
   );

   // A flush already kills the dependent instruction, so it suppresses the stall.
   assign stall = rst_n && hazard && !flush;

   // Bubbles zero every field so downstream stages never see stale operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         RegWrite2_3 <= 1'b0;
         MemRead2_3  <= 1'b0;
         MemWrite2_3 <= 1'b0;
         valid2_3    <= 1'b0;
         ALUop2_3    <= '0;
         wreg2_3     <= '0;
         rsrd2_3     <= '0;
         a2_3        <= '0;
         b2_3        <= '0;
         imm2_3      <= '0;
         pc2_3       <= '0;
         bubble_cnt  <= '0;
      end else if (flush || stall) begin
         RegWrite2_3 <= 1'b0;
         MemRead2_3  <= 1'b0;
         MemWrite2_3 <= 1'b0;
         valid2_3    <= 1'b0;
         ALUop2_3    <= '0;
         wreg2_3     <= '0;
         rsrd2_3     <= '0;
         a2_3        <= '0;
         b2_3        <= '0;
         imm2_3      <= '0;
         pc2_3       <= '0;
         if (stall && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end else begin
         RegWrite2_3 <= RegWrite_d && valid1_2;
         MemRead2_3  <= MemRead_d && valid1_2;
         MemWrite2_3 <= MemWrite_d && valid1_2;
         valid2_3    <= valid1_2;
         ALUop2_3    <= ALUop_d;
         wreg2_3     <= wreg_d;
         rsrd2_3     <= {rs, rd};
         a2_3        <= rdata_a;
         b2_3        <= rdata_b;
         imm2_3      <= imm_d;
         pc2_3       <= pc1_2;
      end
   end

endmodule

// File: tb/tb_stage23_reg.sv
// Randomized and directed bench for stage23_reg against a behavioural model of
// the phase 2/3 register, load-use stall and bubble counter.
module tb_stage23_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr1_2;
   logic        valid1_2;
   logic [15:0] pc1_2;
   logic [15:0] rdata_a;
   logic [15:0] rdata_b;
   logic        RegWrite_d;
   logic        MemRead_d;
   logic        MemWrite_d;
   logic        useA_d;
   logic        useB_d;
   logic [3:0]  ALUop_d;
   logic [2:0]  wreg_d;
   logic [15:0] imm_d;
   logic        flush;
   logic        RegWrite2_3;
   logic        MemRead2_3;
   logic        MemWrite2_3;
   logic        valid2_3;
   logic [3:0]  ALUop2_3;
   logic [2:0]  wreg2_3;
   logic [5:0]  rsrd2_3;
   logic [15:0] a2_3;
   logic [15:0] b2_3;
   logic [15:0] imm2_3;
   logic [15:0] pc2_3;
   logic        stall;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   // Expected contents of the phase 2/3 register
   logic        e_valid, e_rw, e_mr, e_mw;
   logic [3:0]  e_alu;
   logic [2:0]  e_wreg;
   logic [5:0]  e_rsrd;
   logic [15:0] e_a, e_b, e_imm, e_pc, e_cnt;

   stage23_reg dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr1_2    (instr1_2),
      .valid1_2    (valid1_2),
      .pc1_2       (pc1_2),
      .rdata_a     (rdata_a),
      .rdata_b     (rdata_b),
      .RegWrite_d  (RegWrite_d),
      .MemRead_d   (MemRead_d),
      .MemWrite_d  (MemWrite_d),
      .useA_d      (useA_d),
      .useB_d      (useB_d),
      .ALUop_d     (ALUop_d),
      .wreg_d      (wreg_d),
      .imm_d       (imm_d),
      .flush       (flush),
      .RegWrite2_3 (RegWrite2_3),
      .MemRead2_3  (MemRead2_3),
      .MemWrite2_3 (MemWrite2_3),
      .valid2_3    (valid2_3),
      .ALUop2_3    (ALUop2_3),
      .wreg2_3     (wreg2_3),
      .rsrd2_3     (rsrd2_3),
      .a2_3        (a2_3),
      .b2_3        (b2_3),
      .imm2_3      (imm2_3),
      .pc2_3       (pc2_3),
      .stall       (stall),
      .bubble_cnt  (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      {e_valid, e_rw, e_mr, e_mw} = 4'b0;
      e_alu = '0; e_wreg = '0; e_rsrd = '0;
      e_a = '0; e_b = '0; e_imm = '0; e_pc = '0;
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_valid"}, 32'(valid2_3), 32'(e_valid));
      checkOutput({tag, "_regwrite"}, 32'(RegWrite2_3), 32'(e_rw));
      checkOutput({tag, "_memread"}, 32'(MemRead2_3), 32'(e_mr));
      checkOutput({tag, "_memwrite"}, 32'(MemWrite2_3), 32'(e_mw));
      checkOutput({tag, "_aluop"}, 32'(ALUop2_3), 32'(e_alu));
      checkOutput({tag, "_wreg"}, 32'(wreg2_3), 32'(e_wreg));
      checkOutput({tag, "_rsrd"}, 32'(rsrd2_3), 32'(e_rsrd));
      checkOutput({tag, "_a"}, 32'(a2_3), 32'(e_a));
      checkOutput({tag, "_b"}, 32'(b2_3), 32'(e_b));
      checkOutput({tag, "_imm"}, 32'(imm2_3), 32'(e_imm));
      checkOutput({tag, "_pc"}, 32'(pc2_3), 32'(e_pc));
      checkOutput({tag, "_cnt"}, 32'(bubble_cnt), 32'(e_cnt));
   endtask

   // One cycle: drive at negedge, check stall mid-cycle, advance model at posedge, check after.
   task automatic applyStimulus(input string tag, input logic rst_v, input logic flush_v,
                                input logic valid_v, input logic mr_v, input logic rw_v,
                                input logic mw_v, input logic ua, input logic ub,
                                input logic [2:0] rs_v, input logic [2:0] rd_v,
                                input logic [2:0] wreg_v);
      logic [15:0] ins;
      logic        hz;
      logic        exp_stall;
      @(negedge clk);
      ins = 16'($urandom);
      ins[13:11] = rs_v;
      ins[10:8]  = rd_v;
      rst_n = rst_v; flush = flush_v; valid1_2 = valid_v;
      MemRead_d = mr_v; RegWrite_d = rw_v; MemWrite_d = mw_v;
      useA_d = ua; useB_d = ub; wreg_d = wreg_v; instr1_2 = ins;
      pc1_2 = 16'($urandom); rdata_a = 16'($urandom); rdata_b = 16'($urandom);
      imm_d = 16'($urandom); ALUop_d = 4'($urandom_range(0, 8));
      #1;
      hz = valid_v && e_valid && e_mr && ((ua && e_wreg == rs_v) || (ub && e_wreg == rd_v));
      exp_stall = rst_v && hz && !flush_v;
      checkOutput({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      @(posedge clk);
      if (!rst_v) begin
         modelClear();
         e_cnt = '0;
      end else if (flush_v || exp_stall) begin
         modelClear();
         if (exp_stall && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end else begin
         e_valid = valid_v; e_rw = rw_v && valid_v; e_mr = mr_v && valid_v; e_mw = mw_v && valid_v;
         e_alu = ALUop_d; e_wreg = wreg_v; e_rsrd = {rs_v, rd_v};
         e_a = rdata_a; e_b = rdata_b; e_imm = imm_d; e_pc = pc1_2;
      end
      #1;
      checkRegs(tag);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; valid1_2 = 1'b0; instr1_2 = '0; pc1_2 = '0;
      rdata_a = '0; rdata_b = '0; RegWrite_d = 1'b0; MemRead_d = 1'b0; MemWrite_d = 1'b0;
      useA_d = 1'b0; useB_d = 1'b0; ALUop_d = '0; wreg_d = '0; imm_d = '0;
      modelClear();
      e_cnt = '0;

      // Reset, then load r3 followed by a dependent add on rs
      applyStimulus("reset", 0, 0, 1, 1, 1, 0, 1, 1, 3'd3, 3'd3, 3'd3);
      applyStimulus("ld_r3", 1, 0, 1, 1, 1, 0, 0, 0, 3'd1, 3'd2, 3'd3);
      applyStimulus("add_stall", 1, 0, 1, 0, 1, 0, 1, 0, 3'd3, 3'd4, 3'd6);
      checkOutput("add_bubble_cnt", 32'(bubble_cnt), 32'd1);
      applyStimulus("add_go", 1, 0, 1, 0, 1, 0, 1, 0, 3'd3, 3'd4, 3'd6);
      checkOutput("add_latched_valid", 32'(valid2_3), 32'd1);

      // rd matches the load but is not read
      applyStimulus("ld_r3b", 1, 0, 1, 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'd3);
      applyStimulus("no_useb", 1, 0, 1, 0, 0, 1, 0, 0, 3'd1, 3'd3, 3'd0);

      // Hazard and flush together
      applyStimulus("ld_r3c", 1, 0, 1, 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'd3);
      applyStimulus("haz_flush", 1, 1, 1, 0, 1, 0, 1, 1, 3'd3, 3'd3, 3'd1);

      // ALU result producer: forwarding handles it, no stall
      applyStimulus("alu_r5", 1, 0, 1, 0, 1, 0, 0, 0, 3'd1, 3'd2, 3'd5);
      applyStimulus("rd_r5", 1, 0, 1, 0, 1, 0, 1, 1, 3'd5, 3'd5, 3'd2);

      // Reset arriving while a stall is pending
      applyStimulus("ld_r7", 1, 0, 1, 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'd7);
      applyStimulus("rst_mid", 0, 0, 1, 1, 1, 0, 1, 1, 3'd7, 3'd7, 3'd7);
      applyStimulus("resume", 1, 0, 1, 1, 1, 1, 0, 0, 3'd2, 3'd6, 3'd4);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus("rand", ($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      end

      // Saturation: start the counter near its ceiling, then keep stalling
      @(negedge clk);
      force dut.bubble_cnt = 16'hFFFC;
      #1;
      release dut.bubble_cnt;
      e_cnt = 16'hFFFC;
      for (int i = 0; i < 5; i++) begin
         applyStimulus("sat_ld", 1, 0, 1, 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'd2);
         applyStimulus("sat_haz", 1, 0, 1, 0, 0, 0, 1, 0, 3'd2, 3'd1, 3'd0);
      end
      checkOutput("sat_final", 32'(bubble_cnt), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stage23_reg.md
STAGE23_REG -- requirements
Module: stage23_reg

Interface
REQ-001 SHALL have parameter DW, default 16, data/instruction/PC width.
REQ-002 SHALL have parameter RW, default 3, register-number width (8 registers).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port instr1_2  input  DW  instruction from phase 1/2; [13:11]=rs, [10:8]=rd/rt.
REQ-006 SHALL have port valid1_2  input  1  instr1_2 holds a real instruction.
REQ-007 SHALL have port pc1_2  input  DW  PC of instr1_2.
REQ-008 SHALL have ports rdata_a, rdata_b  input  DW each  register-file read data for rs, rd.
REQ-009 SHALL have ports RegWrite_d, MemRead_d, MemWrite_d  input  1 each  decoded controls.
REQ-010 SHALL have ports useA_d, useB_d  input  1 each  instruction actually reads rs / rd.
REQ-011 SHALL have ports ALUop_d  input  4, wreg_d  input  RW, imm_d  input  DW  decoded fields.
REQ-012 SHALL have port flush  input  1  branch taken in phase 3; kill phase 1/2 instruction.
REQ-013 SHALL have outputs RegWrite2_3, MemRead2_3, MemWrite2_3, valid2_3  1 each  latched controls.
REQ-014 SHALL have outputs ALUop2_3 (4), wreg2_3 (RW), rsrd2_3 (2*RW), a2_3, b2_3, imm2_3, pc2_3 (DW)  latched fields.
REQ-015 SHALL have output stall  1  combinational: hold PC and phase 1/2 register this cycle.
REQ-016 SHALL have output bubble_cnt  16  saturating count of inserted bubbles.

Function
REQ-017 SHALL compute hazard = valid1_2 & valid2_3 & MemRead2_3 & ((useA_d & wreg2_3==instr1_2[13:11]) | (useB_d & wreg2_3==instr1_2[10:8])).
REQ-018 SHALL drive stall = hazard & ~flush, same cycle, no register delay.
REQ-019 SHALL, on a clock edge with flush=1, load a bubble: valid2_3, RegWrite2_3, MemRead2_3, MemWrite2_3 = 0; other fields don't-care but SHALL be zero.
REQ-020 SHALL, on a clock edge with stall=1, load a bubble as in REQ-019 and increment bubble_cnt.
REQ-021 SHALL otherwise load all fields from phase 1/2 inputs; controls ANDed with valid1_2; rsrd2_3 = instr1_2[13:8].
REQ-022 SHALL give flush priority over hazard; flush bubble SHALL NOT increment bubble_cnt.
REQ-023 SHALL produce at most one consecutive stall per load: after the bubble MemRead2_3=0 so hazard clears; forwarding covers the rest.
REQ-024 SHALL saturate bubble_cnt at 16'hFFFF (no wrap).
REQ-025 SHALL have latency one cycle from phase 1/2 inputs to all *2_3 outputs.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, clear every registered output and bubble_cnt to 0, overriding flush and stall.
REQ-027 SHALL force stall=0 while rst_n=0.

Structure
REQ-028 SHALL place DW, RW, ALUop encodings and the field bit positions of rs/rd in the shared pipeline package.
REQ-029 SHALL use one sub-module, load_use_detect (combinational hazard of REQ-017); the register bank stays in stage23_reg.

Verification
REQ-030 Load r3 then add using r3 (rs): after load edge, stall=1 one cycle, bubble with valid2_3=0 next edge, add latched edge after, bubble_cnt=1.
REQ-031 Load r3 then instruction with useB_d=0, rd=r3: stall=0, no bubble, bubble_cnt unchanged.
REQ-032 Hazard and flush in same cycle: stall=0, bubble loaded, bubble_cnt unchanged.
REQ-033 Non-load RegWrite2_3=1, wreg2_3=r5, next reads r5: stall=0 (forwarding case).
REQ-034 Preload bubble_cnt to 16'hFFFF via repeated hazards, one more hazard: stays 16'hFFFF.
REQ-035 rst_n=0 mid-stall: next edge all outputs 0, stall=0; rst_n=1 resumes normal loading.
